// File: rtl/micro_sequencer.sv
// micro_sequencer: next-state logic and control state register
// for the microprogrammed control unit, with MOC wait timeout.
module micro_sequencer #(
  parameter int STATE_W = 7,
  parameter int TIMEOUT = 16,
  parameter logic [STATE_W-1:0] ERR_STATE = STATE_W'(5),
  parameter logic [STATE_W-1:0] ILLEGAL_STATE = STATE_W'(5)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        ir,
  input  logic               moc,
  input  logic               flag_z,
  input  logic               flag_n,
  input  logic [2:0]         ns_sel,
  input  logic [1:0]         cond_sel,
  input  logic               cond_inv,
  input  logic [STATE_W-1:0] cr_addr,
  output logic [STATE_W-1:0] state,
  output logic               timeout_err,
  output logic               illegal_op
);

  localparam int CW = $clog2(TIMEOUT);

  localparam logic [2:0] NS_DECODE = 3'd0;
  localparam logic [2:0] NS_INC    = 3'd1;
  localparam logic [2:0] NS_JUMP   = 3'd2;
  localparam logic [2:0] NS_BRANCH = 3'd3;
  localparam logic [2:0] NS_WAIT   = 3'd4;

  logic [5:0]         opcode;
  logic [STATE_W-1:0] inc;
  logic [STATE_W-1:0] enc_state;
  logic               enc_bad;
  logic               cond_raw;
  logic               cond;
  logic [STATE_W-1:0] state_nx;
  logic [CW-1:0]      hold_cnt;
  logic [CW-1:0]      cnt_nx;
  logic               te_set;
  logic               ill_nx;
  logic               unused_ir;

  assign opcode    = ir[31:26];
  assign unused_ir = ^ir[25:0];
  assign inc       = state + STATE_W'(1);

  // Condition mux; selected status optionally inverted.
  always_comb begin
    cond_raw = 1'b1;
    case (cond_sel)
      2'd0:    cond_raw = moc;
      2'd1:    cond_raw = flag_z;
      2'd2:    cond_raw = flag_n;
      default: cond_raw = 1'b1;
    endcase
    cond = cond_raw ^ cond_inv;
  end

  // Opcode encoder; unmapped opcodes go to the illegal handler.
  always_comb begin
    enc_state = ILLEGAL_STATE;
    enc_bad   = 1'b0;
    case (opcode)
      6'h00:   enc_state = STATE_W'(6);
      6'h23:   enc_state = STATE_W'(7);
      6'h2B:   enc_state = STATE_W'(8);
      6'h04:   enc_state = STATE_W'(11);
      6'h02:   enc_state = STATE_W'(12);
      6'h09:   enc_state = STATE_W'(17);
      6'h0F:   enc_state = STATE_W'(18);
      default: begin
        enc_state = ILLEGAL_STATE;
        enc_bad   = 1'b1;
      end
    endcase
  end

  // Next-state select; only a taken wait advances the hold counter.
  always_comb begin
    state_nx = '0;
    cnt_nx   = '0;
    te_set   = 1'b0;
    ill_nx   = 1'b0;
    case (ns_sel)
      NS_DECODE: begin
        state_nx = enc_state;
        ill_nx   = enc_bad;
      end
      NS_INC:    state_nx = inc;
      NS_JUMP:   state_nx = cr_addr;
      NS_BRANCH: state_nx = cond ? cr_addr : inc;
      NS_WAIT: begin
        if (!cond) begin
          state_nx = inc;
        end else if (hold_cnt == CW'(TIMEOUT - 1)) begin
          state_nx = ERR_STATE;
          te_set   = 1'b1;
        end else begin
          state_nx = state;
          cnt_nx   = hold_cnt + CW'(1);
        end
      end
      default:   state_nx = '0;
    endcase
  end

  // Control state register, hold counter and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= '0;
      hold_cnt    <= '0;
      timeout_err <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      state       <= state_nx;
      hold_cnt    <= cnt_nx;
      timeout_err <= timeout_err | te_set;
      illegal_op  <= ill_nx;
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed vector table plus hand-written
// wait/timeout/reset sequences for micro_sequencer.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir;
  logic        moc;
  logic        flag_z;
  logic        flag_n;
  logic [2:0]  ns_sel;
  logic [1:0]  cond_sel;
  logic        cond_inv;
  logic [6:0]  cr_addr;
  logic [6:0]  state;
  logic        timeout_err;
  logic        illegal_op;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [2:0] ns;
    logic [1:0] cs;
    logic       inv;
    logic [6:0] cr;
    logic [5:0] op;
    logic       moc;
    logic       z;
    logic       n;
    logic [6:0] e_state;
    logic       e_te;
    logic       e_io;
  } vec_t;

  vec_t vq[$];

  micro_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .ir          (ir),
    .moc         (moc),
    .flag_z      (flag_z),
    .flag_n      (flag_n),
    .ns_sel      (ns_sel),
    .cond_sel    (cond_sel),
    .cond_inv    (cond_inv),
    .cr_addr     (cr_addr),
    .state       (state),
    .timeout_err (timeout_err),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    logic rst, logic [2:0] ns, logic [1:0] cs, logic inv,
    logic [6:0] cr, logic [5:0] op, logic m, logic z, logic n,
    logic [6:0] es, logic ete, logic eio);
    vec_t v;
    v.rst = rst; v.ns = ns; v.cs = cs; v.inv = inv;
    v.cr = cr; v.op = op; v.moc = m; v.z = z; v.n = n;
    v.e_state = es; v.e_te = ete; v.e_io = eio;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic apply(vec_t v, string nm);
    reset    = v.rst;
    ns_sel   = v.ns;
    cond_sel = v.cs;
    cond_inv = v.inv;
    cr_addr  = v.cr;
    ir       = {v.op, 26'h1555555};
    moc      = v.moc;
    flag_z   = v.z;
    flag_n   = v.n;
    @(posedge clk);
    #1;
    chk({nm, ".state"}, 32'(state), 32'(v.e_state));
    chk({nm, ".timeout_err"}, 32'(timeout_err), 32'(v.e_te));
    chk({nm, ".illegal_op"}, 32'(illegal_op), 32'(v.e_io));
  endtask

  // Shorthands for the hand-written sequences.
  task automatic jump(logic [6:0] a, logic te, string nm);
    apply(mk(0, 3'd2, 2'd0, 0, a, 6'h00, 0, 0, 0, a, te, 0), nm);
  endtask

  task automatic moc_wait(logic m, logic [6:0] es, logic te, string nm);
    apply(mk(0, 3'd4, 2'd0, 1, 7'd0, 6'h3F, m, 0, 0, es, te, 0), nm);
  endtask

  initial begin
    reset = 1'b1; ir = '0; moc = 0; flag_z = 0; flag_n = 0;
    ns_sel = '0; cond_sel = '0; cond_inv = 0; cr_addr = '0;

    //          rst ns  cs  inv cr   op     moc z n  state te io
    vq.push_back(mk(1, 3'd0, 2'd0, 0, 7'd0,  6'h3F, 0, 0, 0, 7'd0,  0, 0));
    vq.push_back(mk(0, 3'd0, 2'd0, 0, 7'd0,  6'h23, 0, 0, 0, 7'd7,  0, 0));
    vq.push_back(mk(0, 3'd0, 2'd0, 0, 7'd0,  6'h3F, 1, 0, 0, 7'd5,  0, 1));
    vq.push_back(mk(0, 3'd1, 2'd0, 0, 7'd0,  6'h3F, 0, 0, 0, 7'd6,  0, 0));
    vq.push_back(mk(0, 3'd2, 2'd0, 0, 7'd11, 6'h00, 0, 0, 0, 7'd11, 0, 0));
    vq.push_back(mk(0, 3'd3, 2'd1, 0, 7'd12, 6'h00, 0, 1, 0, 7'd12, 0, 0));
    vq.push_back(mk(0, 3'd2, 2'd0, 0, 7'd11, 6'h00, 0, 0, 0, 7'd11, 0, 0));
    vq.push_back(mk(0, 3'd3, 2'd1, 0, 7'd12, 6'h00, 0, 0, 0, 7'd12, 0, 0));
    vq.push_back(mk(0, 3'd2, 2'd0, 0, 7'd4,  6'h00, 0, 0, 0, 7'd4,  0, 0));
    vq.push_back(mk(0, 3'd3, 2'd1, 0, 7'd12, 6'h00, 0, 0, 0, 7'd5,  0, 0));
    vq.push_back(mk(0, 3'd2, 2'd0, 0, 7'd4,  6'h00, 0, 0, 0, 7'd4,  0, 0));
    vq.push_back(mk(0, 3'd3, 2'd1, 1, 7'd12, 6'h00, 0, 1, 0, 7'd5,  0, 0));
    vq.push_back(mk(0, 3'd3, 2'd2, 0, 7'd40, 6'h00, 0, 0, 1, 7'd40, 0, 0));
    vq.push_back(mk(0, 3'd3, 2'd3, 1, 7'd60, 6'h00, 0, 0, 0, 7'd41, 0, 0));
    vq.push_back(mk(0, 3'd3, 2'd0, 0, 7'd70, 6'h00, 1, 0, 0, 7'd70, 0, 0));
    vq.push_back(mk(0, 3'd2, 2'd0, 0, 7'd127,6'h00, 0, 0, 0, 7'd127,0, 0));
    vq.push_back(mk(0, 3'd1, 2'd0, 0, 7'd0,  6'h00, 0, 0, 0, 7'd0,  0, 0));
    vq.push_back(mk(0, 3'd2, 2'd0, 0, 7'd20, 6'h00, 0, 0, 0, 7'd20, 0, 0));
    vq.push_back(mk(0, 3'd6, 2'd3, 0, 7'd50, 6'h00, 0, 0, 0, 7'd0,  0, 0));
    vq.push_back(mk(0, 3'd2, 2'd0, 0, 7'd30, 6'h00, 0, 0, 0, 7'd30, 0, 0));
    vq.push_back(mk(0, 3'd7, 2'd3, 0, 7'd50, 6'h00, 0, 0, 0, 7'd0,  0, 0));
    vq.push_back(mk(0, 3'd2, 2'd0, 0, 7'd30, 6'h00, 0, 0, 0, 7'd30, 0, 0));
    vq.push_back(mk(0, 3'd5, 2'd3, 0, 7'd50, 6'h00, 0, 0, 0, 7'd0,  0, 0));
    vq.push_back(mk(0, 3'd0, 2'd0, 0, 7'd0,  6'h00, 0, 0, 0, 7'd6,  0, 0));
    vq.push_back(mk(0, 3'd0, 2'd0, 0, 7'd0,  6'h2B, 0, 0, 0, 7'd8,  0, 0));
    vq.push_back(mk(0, 3'd0, 2'd0, 0, 7'd0,  6'h04, 1, 0, 0, 7'd11, 0, 0));
    vq.push_back(mk(0, 3'd0, 2'd0, 0, 7'd0,  6'h02, 0, 0, 0, 7'd12, 0, 0));
    vq.push_back(mk(0, 3'd0, 2'd0, 0, 7'd0,  6'h09, 0, 0, 0, 7'd17, 0, 0));
    vq.push_back(mk(0, 3'd0, 2'd0, 0, 7'd0,  6'h0F, 0, 0, 0, 7'd18, 0, 0));
    vq.push_back(mk(0, 3'd0, 2'd0, 0, 7'd0,  6'h01, 0, 0, 0, 7'd5,  0, 1));
    vq.push_back(mk(0, 3'd2, 2'd0, 0, 7'd9,  6'h00, 0, 0, 0, 7'd9,  0, 0));
    vq.push_back(mk(1, 3'd0, 2'd0, 0, 7'd0,  6'h3F, 0, 0, 0, 7'd0,  0, 0));

    foreach (vq[i]) apply(vq[i], $sformatf("vec%0d", i));

    // MOC wait: 9 visible 4 cycles, then 10.
    jump(7'd9, 0, "mw.jump");
    for (int i = 0; i < 3; i++) moc_wait(0, 7'd9, 0, $sformatf("mw.hold%0d", i));
    moc_wait(1, 7'd10, 0, "mw.done");

    // Reset mid-wait leaves no hold-count residue.
    jump(7'd9, 0, "rw.jump");
    for (int i = 0; i < 3; i++) moc_wait(0, 7'd9, 0, $sformatf("rw.hold%0d", i));
    apply(mk(1, 3'd4, 2'd0, 1, 7'd0, 6'h3F, 0, 0, 0, 7'd0, 0, 0), "rw.reset");

    // Full timeout: 9 visible exactly 16 cycles, then ERR_STATE.
    jump(7'd9, 0, "to.jump");
    for (int i = 0; i < 15; i++) moc_wait(0, 7'd9, 0, $sformatf("to.hold%0d", i));
    moc_wait(0, 7'd5, 1, "to.divert");

    // timeout_err is sticky through normal operation.
    jump(7'd30, 1, "st.jump");
    apply(mk(0, 3'd1, 2'd0, 0, 7'd0, 6'h00, 0, 0, 0, 7'd31, 1, 0), "st.inc");
    apply(mk(0, 3'd0, 2'd0, 0, 7'd0, 6'h23, 0, 0, 0, 7'd7, 1, 0), "st.dec");
    apply(mk(1, 3'd0, 2'd0, 0, 7'd0, 6'h3F, 0, 0, 0, 7'd0, 0, 0), "st.reset");

    // Branch-to-self does not count toward the timeout.
    jump(7'd9, 0, "bs.jump");
    for (int i = 0; i < 10; i++) moc_wait(0, 7'd9, 0, $sformatf("bs.pre%0d", i));
    apply(mk(0, 3'd3, 2'd3, 0, 7'd9, 6'h00, 0, 0, 0, 7'd9, 0, 0), "bs.self");
    for (int i = 0; i < 15; i++) moc_wait(0, 7'd9, 0, $sformatf("bs.post%0d", i));
    moc_wait(0, 7'd5, 1, "bs.divert");

    // Reset beats an illegal decode in the same cycle.
    apply(mk(1, 3'd0, 2'd0, 0, 7'd0, 6'h3F, 0, 0, 0, 7'd0, 0, 0), "rd.reset");
    apply(mk(0, 3'd0, 2'd0, 0, 7'd0, 6'h23, 0, 0, 0, 7'd7, 0, 0), "rd.dec");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
